// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 bus arbiter: FSM state encoding and bus source indices.
package lc3_bus_pkg;

    localparam int LC3_N_REQ = 4;

    localparam int REQ_PC     = 0;
    localparam int REQ_MDR    = 1;
    localparam int REQ_ALU    = 2;
    localparam int REQ_MARMUX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lc3_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: lowest requesting index at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// LC-3 shared-bus arbiter: round-robin ownership of the tri-state drivers with a hold limit
// and an all-off turnaround gap between owners.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner, all gates off; grant the round-robin winner
//   ST_GRANT | owner's gate on; leave on release or hold-limit preemption
//   ST_TURN  | all gates off for TURN_CYC cycles; re-arbitrate on the last
module lc3_bus_arbiter
    import lc3_bus_pkg::*;
#(
    parameter int N_REQ    = LC3_N_REQ,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gate,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     preempt
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
    logic [N_REQ-1:0] gate_q, gate_d;
    logic             bus_busy_q, bus_busy_d;
    logic             preempt_q, preempt_d;

    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic             others_req;
    logic [IW-1:0]    owner_next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        turn_cnt_d     = turn_cnt_q;
        preempt_d      = 1'b0;
        others_req     = |(req & ~gate_q);
        owner_next_ptr = (owner_q == IDX_LAST) ? '0 : owner_q + IW'(1);

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = TURN_LOAD;
                    rr_ptr_d   = owner_next_ptr;
                end else if (hold_cnt_q >= HOLD_LAST && others_req) begin
                    // >= rather than == so a long-saturated lone owner still yields promptly
                    state_d    = ST_TURN;
                    turn_cnt_d = TURN_LOAD;
                    rr_ptr_d   = owner_next_ptr;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_TURN: begin
                if (turn_cnt_q != '0) begin
                    turn_cnt_d = turn_cnt_q - TW'(1);
                end else if (pick_found) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gate_d = '0;
        if (state_d == ST_GRANT) begin
            gate_d[owner_d] = 1'b1;
        end
        bus_busy_d = (state_d == ST_GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            gate_q     <= '0;
            bus_busy_q <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            gate_q     <= gate_d;
            bus_busy_q <= bus_busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gate     = gate_q;
    assign owner    = owner_q;
    assign bus_busy = bus_busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Self-checking bench for lc3_bus_arbiter: vector table through a scoreboard queue,
// hand sequences for async reset, and a randomized invariant run.
module tb_lc3_bus_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 8;
    localparam int TURN_CYC = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gate;
    logic [1:0] owner;
    logic       bus_busy;
    logic       preempt;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gate;
        logic       pre;
    } vec_t;

    typedef struct {
        logic [3:0] gate;
        logic       pre;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    lc3_bus_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gate     (gate),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic p);
        vec_t v;
        v.req  = r;
        v.gate = g;
        v.pre  = p;
        vecs.push_back(v);
    endtask

    // Drive one request pattern, queue its expectation, and score it after the next edge.
    task automatic apply(input logic [3:0] r, input logic [3:0] g, input logic p, input string tag);
        exp_t e;
        @(negedge clk);
        req   = r;
        e.gate = g;
        e.pre  = p;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " gate"}, int'(gate), int'(e.gate));
        check({e.tag, " preempt"}, int'(preempt), int'(e.pre));
        check({e.tag, " bus_busy"}, int'(bus_busy), int'(|e.gate));
        if (e.gate != 4'b0000) begin
            check({e.tag, " owner"}, int'(owner), idx_of(e.gate));
        end
    endtask

    logic [3:0] last_nz;
    int         zrun;

    initial begin
        // reset release -> first grant to index 0, then release
        add(4'b1111, 4'b0001, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        // lone requester keeps the bus with no preemption
        for (int i = 0; i < 20; i++) add(4'b0100, 4'b0100, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        // two competing sources: MAX_HOLD on, TURN_CYC off, preempt pulses
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MAX_HOLD; i++) add(4'b0011, 4'b0001, 1'b0);
            add(4'b0011, 4'b0000, 1'b1);
            for (int i = 0; i < MAX_HOLD; i++) add(4'b0011, 4'b0010, 1'b0);
            add(4'b0011, 4'b0000, 1'b1);
        end
        // owner 3 released with 1001 pending -> wrap to index 0
        add(4'b1000, 4'b1000, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) add(4'b1001, 4'b1000, 1'b0);
        add(4'b1001, 4'b0000, 1'b1);
        add(4'b1001, 4'b0001, 1'b0);
        add(4'b1001, 4'b0001, 1'b0);
        add(4'b1000, 4'b0000, 1'b0);
        add(4'b1000, 4'b1000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        // request dropped on the grant edge still gets one GRANT cycle
        add(4'b0100, 4'b0100, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 3; i++) apply(4'b1111, 4'b0000, 1'b0, "in_reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].req, vecs[i].gate, vecs[i].pre, $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a grant
        apply(4'b0010, 4'b0010, 1'b0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst gate", int'(gate), 0);
        check("async_rst bus_busy", int'(bus_busy), 0);
        check("async_rst preempt", int'(preempt), 0);
        apply(4'b0010, 4'b0000, 1'b0, "async_hold");
        apply(4'b0010, 4'b0000, 1'b0, "async_hold");
        rst_n = 1'b1;
        apply(4'b0010, 4'b0010, 1'b0, "post_async");

        // randomized invariant run
        last_nz = gate;
        zrun    = TURN_CYC;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            @(posedge clk);
            #1;
            check("rand onehot0", int'($countones(gate) <= 1), 1);
            check("rand bus_busy", int'(bus_busy), int'(|gate));
            check("rand preempt_idle", int'(preempt & (|gate)), 0);
            if (gate == 4'b0000) begin
                zrun++;
            end else begin
                if (last_nz != 4'b0000 && gate != last_nz) begin
                    check("rand handover_gap", int'(zrun >= TURN_CYC), 1);
                end
                last_nz = gate;
                zrun    = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_bus_arbiter.md
# lc3_bus_arbiter

Sequential controller for the LC-3 shared 16-bit bus. Each bus source drives the bus through its own 16-bit tri-state buffer. This block decides which buffer's `triStateCtrl` is asserted, so at most one driver is enabled at any time. Arbitration is round-robin, with a hold limit and a mandatory turnaround gap between owners. It sits between the control-unit request lines and the per-source tri-state buffers.

## Interface
Parameters:
- `N_REQ`, 4: number of bus sources/requesters (index 0 = PC, 1 = MDR, 2 = ALU, 3 = MARMUX).
- `MAX_HOLD`, 8: maximum consecutive owned cycles while another requester waits; minimum 1.
- `TURN_CYC`, 1: all-gates-off cycles between two owners; minimum 1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `N_REQ`: level request per source; held high for as long as the source wants the bus.
- `gate`, out, `N_REQ`: one-hot or zero tri-state enables, registered; drive each buffer's `triStateCtrl`.
- `owner`, out, `$clog2(N_REQ)`: index of the current owner; valid only when `bus_busy` = 1.
- `bus_busy`, out, 1: high in GRANT (equals OR of `gate`).
- `preempt`, out, 1: one-cycle pulse when an owner is forcibly released at `MAX_HOLD`.

## Operation
- **State machine:** IDLE, GRANT, TURN; registered state.
- **IDLE:**
  - `gate` = 0.
  - If `req` ≠ 0, pick the winner by round-robin starting at `rr_ptr`, load `owner`, and go to GRANT.
  - The winner's `gate` bit is high on the cycle after that edge.
- **GRANT:** `gate` = one-hot(`owner`); `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
  - If `req[owner]` = 0: go to TURN and clear `gate`.
  - Else if `hold_cnt` = `MAX_HOLD`−1 and some other `req` bit is high: go to TURN, clear `gate`, and pulse `preempt` for one cycle coincident with the first TURN cycle.
  - Else: stay in GRANT. A lone requester keeps the bus indefinitely.
- **TURN:**
  - `gate` = 0 for exactly `TURN_CYC` cycles.
  - On entry, `rr_ptr` ← `owner`+1, wrapping modulo `N_REQ`.
  - On the last TURN cycle, arbitrate as in IDLE: if any request is pending go to GRANT, else go to IDLE.
- **Round-robin:** the lowest index at or above `rr_ptr` with `req` set wins, wrapping to 0. `rr_ptr` changes only on entry to TURN.
- **Invariant:** `gate` is never multi-hot, and two different owners are never enabled on adjacent cycles.
- **Request drop at grant:** a request that drops on the same edge its grant is issued still yields one GRANT cycle, then TURN. There is no cancellation.
- **Reset:** asynchronous. Clears `gate`, `bus_busy`, `preempt`, `owner`, `rr_ptr`, `hold_cnt`, turnaround counter; state ← IDLE.
  - Reset asserted mid-GRANT forces all buffers to high-Z immediately, without waiting for a clock.
  - After reset release, the first grant follows normal IDLE rules with `rr_ptr` = 0.

## Timing
- **Grant latency from IDLE:** `req` sampled high at edge k → `gate` high after edge k (visible in cycle k+1).
- **Release latency:** `req[owner]` sampled low at edge k → `gate` low after edge k.
- **Bus handover:** minimum gap between owners is `TURN_CYC` idle cycles.
- **Back-to-back service period:** for two continuously requesting sources, each cycle of service is `MAX_HOLD` + `TURN_CYC` cycles.
- **Outputs:** all are registered; there is no combinational path from `req` to `gate`.
- **Counter widths:**
  - `hold_cnt`: `$clog2(MAX_HOLD+1)` bits.
  - Turnaround counter: `$clog2(TURN_CYC+1)` bits.

## Structure
- **Package `lc3_bus_pkg`:**
  - State enum (IDLE/GRANT/TURN).
  - Requester index constants `REQ_PC`, `REQ_MDR`, `REQ_ALU`, `REQ_MARMUX`.
  - Default `N_REQ` constant.
- **Sub-module `rr_pick`:**
  - Purely combinational, `N_REQ`-wide round-robin priority encoder.
  - Inputs: `req`, `ptr`. Outputs: `idx`, `found`.
  - Instantiated once; used in IDLE and in the last TURN cycle.

## Test plan
1. **Reset and first grant:** hold `rst_n`=0 with `req`=4'b1111, then release → `gate`=0 throughout reset; first grant goes to `gate`=4'b0001 one cycle after the first edge.
2. **Single requester:** `req`=4'b0100 held for 20 cycles, then dropped → `gate`=4'b0100 for the whole period with no `preempt`. `gate`=0 one cycle after the drop, then TURN, then IDLE.
3. **Two competing requesters:** `req`=4'b0011 held, `MAX_HOLD`=8, `TURN_CYC`=1 → `gate` shows 8 cycles of 0001, 1 cycle of 0, 8 cycles of 0010, 1 cycle of 0, repeating. `preempt` pulses at each handover.
4. **Round-robin wrap:** owner=3 releases while `req`=4'b1001 → after the TURN cycle, `gate`=4'b0001 (wrap). Owner 3 is not re-granted before index 0.
5. **Asynchronous reset mid-grant:** `rst_n` dropped between edges during GRANT → `gate`=0 with no clock. After release with `req`=4'b0010, the grant goes to index 1 one cycle later.
6. **Invariant check:** random `req` for 10k cycles with an assertion → `gate` is never multi-hot, and a change of owner is always separated by ≥ `TURN_CYC` zero cycles.
